// File: rtl/finder_scan.sv
// finder_scan: scans a 1-bit frame row-major and then column-major,
// run-length encodes every line and flags the centers of windows whose
// five runs (dark/light/dark/light/dark) match the 1:1:3:1:1 finder ratio.
// Build macro FINDER_HIT_COUNT_EN adds a saturating 16-bit hit_count output.
module finder_scan #(
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 480
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              rd_en_out,
  output logic [17:0]       addr_out,
  input  logic              pixel_in,
  output logic [WIDTH-1:0]  horz_patterns,
  output logic [HEIGHT-1:0] vert_patterns,
  output logic              patterns_valid,
  output logic              busy_out
`ifdef FINDER_HIT_COUNT_EN
  ,
  output logic [15:0]       hit_count
`endif
);

  localparam logic [8:0]  W_LEN    = 9'(WIDTH);
  localparam logic [8:0]  H_LEN    = 9'(HEIGHT);
  localparam logic [8:0]  W_LAST   = 9'(WIDTH - 1);
  localparam logic [8:0]  H_LAST   = 9'(HEIGHT - 1);
  localparam logic [17:0] ROW_STEP = 18'(WIDTH);
  localparam logic [8:0]  RUN_MAX  = 9'd511;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HSCAN,
    S_VSCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Read sequencer state. r_line is the outer index (row in HSCAN, column
  // in VSCAN) and r_pos the position of the current read within its line.
  state_t      r_state;
  logic [8:0]  r_line;
  logic [8:0]  r_pos;
  logic [17:0] r_addr;
  logic        r_rd_en;
  logic        r_drain;
  logic        r_valid;
  logic        r_busy;

  // Side pipeline: flags of each read, delayed to meet its returning pixel.
  logic        r_p1_vld, r_p1_vert, r_p1_last;
  logic [8:0]  r_p1_pos;
  logic        r_p2_vld, r_p2_vert, r_p2_last;
  logic [8:0]  r_p2_pos;

  // Per-line run state and the history window (index 0 = oldest run).
  logic        r_run_color;
  logic [8:0]  r_run_len;
  logic [4:0][8:0] r_hist;
  logic [2:0]  r_fill;

  logic [WIDTH-1:0]  r_horz;
  logic [HEIGHT-1:0] r_vert;

  logic w_accept;
  logic w_rd_last;

  assign w_accept  = (r_state == S_IDLE) && start_in;
  assign w_rd_last = (r_state == S_VSCAN) ? (r_pos == H_LAST) : (r_pos == W_LAST);

  // Scan sequencer: walks both passes, then drains the read pipeline.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_pos   <= '0;
      r_addr  <= '0;
      r_rd_en <= 1'b0;
      r_drain <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (start_in) begin
            r_state <= S_HSCAN;
            r_line  <= '0;
            r_pos   <= '0;
            r_addr  <= '0;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_HSCAN: begin
          if (r_pos == W_LAST) begin
            r_pos <= '0;
            if (r_line == H_LAST) begin
              // Straight into the column pass, no idle cycle between.
              r_state <= S_VSCAN;
              r_line  <= '0;
              r_addr  <= '0;
            end else begin
              r_line <= r_line + 9'd1;
              r_addr <= r_addr + 18'd1;
            end
          end else begin
            r_pos  <= r_pos + 9'd1;
            r_addr <= r_addr + 18'd1;
          end
        end
        S_VSCAN: begin
          if (r_pos == H_LAST) begin
            r_pos <= '0;
            if (r_line == W_LAST) begin
              r_state <= S_DRAIN;
              r_line  <= '0;
              r_addr  <= '0;
              r_rd_en <= 1'b0;
              r_drain <= 1'b0;
            end else begin
              r_line <= r_line + 9'd1;
              r_addr <= 18'(r_line) + 18'd1;
            end
          end else begin
            r_pos  <= r_pos + 9'd1;
            r_addr <= r_addr + ROW_STEP;
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_rd_en <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage flag pipeline matching the frame buffer read latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_p1_vld <= 1'b0; r_p1_vert <= 1'b0; r_p1_last <= 1'b0; r_p1_pos <= '0;
      r_p2_vld <= 1'b0; r_p2_vert <= 1'b0; r_p2_last <= 1'b0; r_p2_pos <= '0;
    end else if (w_accept) begin
      r_p1_vld <= 1'b0; r_p1_vert <= 1'b0; r_p1_last <= 1'b0; r_p1_pos <= '0;
      r_p2_vld <= 1'b0; r_p2_vert <= 1'b0; r_p2_last <= 1'b0; r_p2_pos <= '0;
    end else begin
      r_p1_vld  <= r_rd_en;
      r_p1_vert <= (r_state == S_VSCAN);
      r_p1_last <= w_rd_last;
      r_p1_pos  <= r_pos;
      r_p2_vld  <= r_p1_vld;
      r_p2_vert <= r_p1_vert;
      r_p2_last <= r_p1_last;
      r_p2_pos  <= r_p1_pos;
    end
  end

  function automatic logic [2:0] fill_inc(input logic [2:0] f);
    return (f == 3'd5) ? 3'd5 : f + 3'd1;
  endfunction

  logic            w_vld, w_first, w_chg, w_close_last;
  logic            w_test_a, w_test_b, w_test;
  logic [8:0]      w_inc_len, w_cur_len, w_e, w_line_len;
  logic [4:0][8:0] w_h0, w_h1, w_h2, w_win;
  logic [2:0]      w_f0, w_f1, w_f2, w_wfill;

  // Run encoder: up to two runs can close on one pixel (a color change on
  // the last pixel closes the old run and the new one-pixel run).
  always_comb begin
    w_vld        = r_p2_vld;
    w_first      = (r_p2_pos == 9'd0);
    w_line_len   = r_p2_vert ? H_LEN : W_LEN;
    w_chg        = w_vld && !w_first && (pixel_in != r_run_color);
    w_close_last = w_vld && r_p2_last;
    w_inc_len    = (r_run_len == RUN_MAX) ? RUN_MAX : r_run_len + 9'd1;
    w_cur_len    = (w_first || w_chg) ? 9'd1 : w_inc_len;

    w_h0 = w_first ? '0 : r_hist;
    w_f0 = w_first ? 3'd0 : r_fill;
    w_h1 = w_h0;
    w_f1 = w_f0;
    if (w_chg) begin
      w_h1 = {r_run_len, w_h0[4:1]};
      w_f1 = fill_inc(w_f0);
    end
    w_h2 = w_h1;
    w_f2 = w_f1;
    if (w_close_last) begin
      w_h2 = {w_cur_len, w_h1[4:1]};
      w_f2 = fill_inc(w_f1);
    end

    // Only one of the two closing runs can be dark; test the window it ends.
    w_test_a = w_chg && r_run_color;
    w_test_b = w_close_last && pixel_in;
    w_win    = w_test_a ? w_h1 : w_h2;
    w_wfill  = w_test_a ? w_f1 : w_f2;
    w_e      = w_test_a ? r_p2_pos : w_line_len;
    w_test   = (w_test_a || w_test_b) && (w_wfill == 3'd5);
  end

  logic [11:0]      w_sum;
  logic [15:0]      w_t1, w_t3, w_t9;
  logic [4:0][15:0] w_r14;
  logic [4:0]       w_ratio_ok;
  logic [12:0]      w_ctr;
  logic             w_hit;
  logic [WIDTH-1:0]  w_hset;
  logic [HEIGHT-1:0] w_vset;

  assign w_sum = 12'(w_win[0]) + 12'(w_win[1]) + 12'(w_win[2]) +
                 12'(w_win[3]) + 12'(w_win[4]);
  assign w_t1  = 16'(w_sum);
  assign w_t3  = w_t1 * 16'd3;
  assign w_t9  = w_t1 * 16'd9;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_ratio
      assign w_r14[gi] = 16'(w_win[gi]) * 16'd14;
      if (gi == 2) begin : g_mid
        assign w_ratio_ok[gi] = (w_r14[gi] >= w_t3) && (w_r14[gi] <= w_t9);
      end else begin : g_side
        assign w_ratio_ok[gi] = (w_r14[gi] >= w_t1) && (w_r14[gi] <= w_t3);
      end
    end
  endgenerate

  // Center of the middle dark run; a wrapped (negative) value fails the bound.
  assign w_ctr = 13'(w_e) + 13'(w_win[2] >> 1) - 13'(w_win[4])
               - 13'(w_win[3]) - 13'(w_win[2]);
  assign w_hit = w_test && (w_sum >= 12'd7) && (&w_ratio_ok) &&
                 (w_ctr < 13'(w_line_len));

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_hset
      assign w_hset[gi] = w_hit && !r_p2_vert && (w_ctr == 13'(gi));
    end
    for (gi = 0; gi < HEIGHT; gi++) begin : g_vset
      assign w_vset[gi] = w_hit && r_p2_vert && (w_ctr == 13'(gi));
    end
  endgenerate

  // Run state register, updated once per returning pixel.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_run_color <= 1'b0;
      r_run_len   <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
    end else if (w_accept) begin
      r_run_color <= 1'b0;
      r_run_len   <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
    end else if (w_vld) begin
      r_run_color <= pixel_in;
      r_run_len   <= w_cur_len;
      r_hist      <= w_h2;
      r_fill      <= w_f2;
    end
  end

  // Pattern vectors: bits only accumulate during a scan, cleared on start.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_horz <= '0;
      r_vert <= '0;
    end else if (w_accept) begin
      r_horz <= '0;
      r_vert <= '0;
    end else begin
      r_horz <= r_horz | w_hset;
      r_vert <= r_vert | w_vset;
    end
  end

`ifdef FINDER_HIT_COUNT_EN
  logic [15:0] r_hit_count;

  // Saturating count of finder hits over both passes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_hit_count <= '0;
    end else if (w_accept) begin
      r_hit_count <= '0;
    end else if (w_hit && (r_hit_count != 16'hFFFF)) begin
      r_hit_count <= r_hit_count + 16'd1;
    end
  end

  assign hit_count = r_hit_count;
`endif

  assign rd_en_out      = r_rd_en;
  assign addr_out       = r_addr;
  assign horz_patterns  = r_horz;
  assign vert_patterns  = r_vert;
  assign patterns_valid = r_valid;
  assign busy_out       = r_busy;

endmodule

// File: tb/tb_finder_scan.sv
// tb_finder_scan: table-driven frames on a small 16x12 frame buffer model
// with a scoreboard of expected pattern vectors, plus reset and timing cases.
module tb_finder_scan;

  localparam int W   = 16;
  localparam int H   = 12;
  localparam int WH  = W * H;
  localparam int TOT = 2 * WH;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic          pixel_in;
  logic          rd_en_out;
  logic [17:0]   addr_out;
  logic [W-1:0]  horz_patterns;
  logic [H-1:0]  vert_patterns;
  logic          patterns_valid;
  logic          busy_out;
`ifdef FINDER_HIT_COUNT_EN
  logic [15:0]   hit_count;
`endif

  finder_scan #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .rd_en_out      (rd_en_out),
    .addr_out       (addr_out),
    .pixel_in       (pixel_in),
    .horz_patterns  (horz_patterns),
    .vert_patterns  (vert_patterns),
    .patterns_valid (patterns_valid),
    .busy_out       (busy_out)
`ifdef FINDER_HIT_COUNT_EN
    ,
    .hit_count      (hit_count)
`endif
  );

  always #5 clk = ~clk;

  // mode 0: rows lo..hi get runs D,L,D,L,D starting at column st
  // mode 1: columns lo..hi get the runs starting at row st
  // mode 2: 7x7 finder with top-left corner (x=st, y=lo)
  typedef struct {
    int           mode;
    int           lo;
    int           hi;
    int           st;
    int           ra, rb, rc, rd, re;
    logic [W-1:0] eh;
    logic [H-1:0] ev;
    int           hits;
  } vec_t;

  typedef struct {
    logic [W-1:0] eh;
    logic [H-1:0] ev;
    int           hits;
    int           id;
  } exp_t;

  localparam int NV = 11;
  vec_t  vecs [NV];
  exp_t  sb [$];
  logic  fb [WH];
  int    n_vec  = 0;
  int    n_fail = 0;

  // Frame buffer model: data for a read strobed in cycle k appears in k+2.
  logic st1 = 1'b0, st2 = 1'b0;
  initial begin
    pixel_in = 1'b0;
    forever begin
      @(negedge clk);
      pixel_in = st2;
      st2      = st1;
      if (rd_en_out === 1'b1 && int'(addr_out) < WH) st1 = fb[int'(addr_out)];
      else st1 = 1'b0;
    end
  end

  function automatic vec_t mk(input int mode, input int lo, input int hi, input int st,
                              input int ra, input int rb, input int rc, input int rd,
                              input int re, input logic [W-1:0] eh,
                              input logic [H-1:0] ev, input int hits);
    vec_t v;
    v.mode = mode; v.lo = lo; v.hi = hi; v.st = st;
    v.ra = ra; v.rb = rb; v.rc = rc; v.rd = rd; v.re = re;
    v.eh = eh; v.ev = ev; v.hits = hits;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic paint(input vec_t v);
    int rl [5];
    int p, ax, ay, ch;
    rl[0] = v.ra; rl[1] = v.rb; rl[2] = v.rc; rl[3] = v.rd; rl[4] = v.re;
    for (int i = 0; i < WH; i++) fb[i] = 1'b0;
    if (v.mode == 2) begin
      for (int dy = 0; dy < 7; dy++) begin
        for (int dx = 0; dx < 7; dx++) begin
          ax = (dx > 3) ? dx - 3 : 3 - dx;
          ay = (dy > 3) ? dy - 3 : 3 - dy;
          ch = (ax > ay) ? ax : ay;
          fb[(v.lo + dy) * W + v.st + dx] = (ch != 2);
        end
      end
    end else begin
      for (int l = v.lo; l <= v.hi; l++) begin
        p = v.st;
        for (int k = 0; k < 5; k++) begin
          for (int n = 0; n < rl[k]; n++) begin
            if (v.mode == 0) fb[l * W + p] = (k % 2 == 0);
            else             fb[p * W + l] = (k % 2 == 0);
            p++;
          end
        end
      end
    end
  endtask

  function automatic int exp_addr(input int cyc);
    int j;
    if (cyc <= WH) return cyc - 1;
    j = cyc - 1 - WH;
    return (j % H) * W + (j / H);
  endfunction

  task automatic run_frame(input int id, input vec_t v);
    exp_t e;
    int   rd_err, addr_err, busy_err, val_err, seen;
    rd_err = 0; addr_err = 0; busy_err = 0; val_err = 0; seen = 0;
    paint(v);
    e.eh = v.eh; e.ev = v.ev; e.hits = v.hits; e.id = id;
    sb.push_back(e);
    @(negedge clk); start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
    for (int cyc = 1; cyc <= TOT + 6; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 50) start_in = 1'b1;
      if (cyc == 51) start_in = 1'b0;
      if (rd_en_out !== (cyc <= TOT)) rd_err++;
      if (cyc <= TOT && int'(addr_out) != exp_addr(cyc)) addr_err++;
      if (busy_out !== (cyc <= TOT + 3)) busy_err++;
      if (cyc == TOT + 3) begin
        if (patterns_valid === 1'b1 && sb.size() > 0) begin
          seen = 1;
          e = sb.pop_front();
          chk($sformatf("horz_f%0d", e.id), 32'(horz_patterns), 32'(e.eh));
          chk($sformatf("vert_f%0d", e.id), 32'(vert_patterns), 32'(e.ev));
`ifdef FINDER_HIT_COUNT_EN
          chk($sformatf("hits_f%0d", e.id), 32'(hit_count), 32'(e.hits));
`endif
        end
      end else if (patterns_valid !== 1'b0) begin
        val_err++;
      end
    end
    if (seen == 0) begin
      chk($sformatf("valid_seen_f%0d", id), 32'(seen), 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
    end
    chk($sformatf("rd_en_f%0d", id), 32'(rd_err), 32'd0);
    chk($sformatf("addr_f%0d", id), 32'(addr_err), 32'd0);
    chk($sformatf("busy_f%0d", id), 32'(busy_err), 32'd0);
    chk($sformatf("valid_f%0d", id), 32'(val_err), 32'd0);
    chk($sformatf("hold_horz_f%0d", id), 32'(horz_patterns), 32'(v.eh));
    chk($sformatf("hold_vert_f%0d", id), 32'(vert_patterns), 32'(v.ev));
    $display("frame %0d: horz=%h vert=%h exp_hits=%0d", id, horz_patterns,
             vert_patterns, v.hits);
  endtask

  initial begin
    vecs[0]  = mk(0, 5, 5, 2, 1, 1, 3, 1, 1, 16'h0020, 12'h000, 1);
    vecs[1]  = mk(0, 4, 6, 1, 2, 2, 6, 2, 2, 16'h0100, 12'h000, 3);
    vecs[2]  = mk(0, 7, 7, 3, 2, 2, 2, 2, 2, 16'h0000, 12'h000, 0);
    vecs[3]  = mk(0, 9, 9, 2, 2, 2, 6, 2, 2, 16'h0200, 12'h000, 1);
    vecs[4]  = mk(2, 3, 3, 4, 0, 0, 0, 0, 0, 16'h0080, 12'h040, 6);
    vecs[5]  = mk(0, 1, 1, 0, 2, 1, 3, 1, 2, 16'h0000, 12'h000, 0);
    vecs[6]  = mk(1, 0, 0, 0, 1, 1, 3, 1, 1, 16'h0000, 12'h008, 1);
    vecs[7]  = mk(1, 15, 15, 5, 1, 1, 3, 1, 1, 16'h0000, 12'h100, 1);
    vecs[8]  = mk(0, 0, -1, 0, 0, 0, 0, 0, 0, 16'h0000, 12'h000, 0);
    vecs[9]  = mk(0, 11, 11, 9, 1, 1, 3, 1, 1, 16'h1000, 12'h000, 1);
    vecs[10] = mk(0, 2, 2, 1, 2, 2, 5, 2, 2, 16'h0080, 12'h000, 1);

    rst_in   = 1'b1;
    start_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en_out), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_horz", 32'(horz_patterns), 32'd0);
    chk("rst_vert", 32'(vert_patterns), 32'd0);
    chk("rst_valid", 32'(patterns_valid), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
`ifdef FINDER_HIT_COUNT_EN
    chk("rst_hits", 32'(hit_count), 32'd0);
`endif
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy_out), 32'd0);

    // Mid-scan reset: a hit from row 5 is already set when reset arrives.
    paint(vecs[0]);
    @(negedge clk); start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
    repeat (99) @(negedge clk);
    chk("pre_rst_horz", 32'(horz_patterns), 32'h0020);
    chk("pre_rst_busy", 32'(busy_out), 32'd1);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_rd_en", 32'(rd_en_out), 32'd0);
    chk("mid_rst_addr", 32'(addr_out), 32'd0);
    chk("mid_rst_horz", 32'(horz_patterns), 32'd0);
    chk("mid_rst_vert", 32'(vert_patterns), 32'd0);
    chk("mid_rst_valid", 32'(patterns_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy_out), 32'd0);
    $display("mid-scan reset applied at cycle 100");
    @(negedge clk); rst_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(busy_out), 32'd0);

    // Finder first: it also proves the restart begins at address 0.
    run_frame(4, vecs[4]);
    for (int i = 0; i < NV; i++) begin
      if (i != 4) run_frame(i, vecs[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
